// File: rtl/cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmd_arbiter
// Description : Two-requester round-robin command arbiter in front of an SPI
//               transmitter. A requester's send pulse is latched as pending.
//               The winner's region_end and a start pulse go to the
//               transmitter. Transmitter word reads are forwarded to the
//               granted requester, one at a time.
//               Optional macro CMD_ARB_TIMEOUT_EN adds a 10-bit watchdog
//               that aborts a BUSY phase that stalls for 1023 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_arbiter (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [1:0]  req_send,
    input  logic [31:0] req_end0,
    input  logic [31:0] req_end1,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [1:0]  req_rdone,
    output logic [1:0]  req_r_en,
    output logic [31:0] req_ptr,
    output logic [1:0]  req_done,
    output logic        tx_send,
    output logic [31:0] tx_end,
    input  logic        tx_r_en,
    input  logic [31:0] tx_ptr,
    output logic [31:0] tx_data,
    output logic        tx_rdone,
    input  logic        tx_done,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        abort_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [1:0]  r_pending;
    logic [1:0]  w_pend_clr;
    logic        r_last;
    logic        w_last_nx;
    logic [31:0] r_end0;
    logic [31:0] r_end1;

    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nx;
    logic [31:0] r_tx_end;
    logic [31:0] w_tx_end_nx;
    logic        r_tx_send;
    logic        w_tx_send_nx;
    logic [31:0] r_tx_data;
    logic [31:0] w_tx_data_nx;
    logic        r_tx_rdone;
    logic        w_tx_rdone_nx;
    logic [1:0]  r_req_done;
    logic [1:0]  w_req_done_nx;
    logic [1:0]  r_req_r_en;
    logic [1:0]  w_req_r_en_nx;
    logic [31:0] r_req_ptr;
    logic [31:0] w_req_ptr_nx;
    logic        r_busy;

    // Round-robin pick: on a tie the requester that was not served last wins.
    logic        w_win;
    // Index of the current owner (grant is one-hot while BUSY).
    logic        w_g;

    assign w_g = r_grant[1];

    // Winner selection against the last-granted index.
    always_comb begin
        w_win = 1'b0;
        if (r_pending == 2'b11) begin
            w_win = ~r_last;
        end else if (r_pending[1]) begin
            w_win = 1'b1;
        end
    end

`ifdef CMD_ARB_TIMEOUT_EN
    logic [9:0]  r_tmo_cnt;
    logic [9:0]  w_tmo_cnt_nx;
    logic        r_abort_err;
    logic        w_abort_nx;
`endif

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        w_state_nx    = r_state;
        w_pend_clr    = 2'b00;
        w_last_nx     = r_last;
        w_grant_nx    = r_grant;
        w_tx_end_nx   = r_tx_end;
        w_tx_send_nx  = 1'b0;
        w_tx_data_nx  = r_tx_data;
        w_tx_rdone_nx = 1'b0;
        w_req_done_nx = 2'b00;
        w_req_r_en_nx = r_req_r_en;
        w_req_ptr_nx  = r_req_ptr;
`ifdef CMD_ARB_TIMEOUT_EN
        w_tmo_cnt_nx  = r_tmo_cnt;
        w_abort_nx    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_nx    = ST_BUSY;
                    w_grant_nx    = w_win ? 2'b10 : 2'b01;
                    w_tx_end_nx   = w_win ? r_end1 : r_end0;
                    w_tx_send_nx  = 1'b1;
                    w_req_r_en_nx = 2'b00;
`ifdef CMD_ARB_TIMEOUT_EN
                    w_tmo_cnt_nx  = 10'd0;
`endif
                end
            end
            ST_BUSY: begin
                if (tx_done) begin
                    // Transfer complete: release the owner, any open read is dropped.
                    w_state_nx    = ST_IDLE;
                    w_req_done_nx = r_grant;
                    w_pend_clr    = r_grant;
                    w_last_nx     = w_g;
                    w_grant_nx    = 2'b00;
                    w_req_r_en_nx = 2'b00;
`ifdef CMD_ARB_TIMEOUT_EN
                end else if (r_tmo_cnt == 10'd1023) begin
                    // Watchdog expiry: abort as if the transfer had ended.
                    w_state_nx    = ST_IDLE;
                    w_req_done_nx = r_grant;
                    w_abort_nx    = 1'b1;
                    w_pend_clr    = r_grant;
                    w_last_nx     = w_g;
                    w_grant_nx    = 2'b00;
                    w_req_r_en_nx = 2'b00;
`endif
                end else begin
`ifdef CMD_ARB_TIMEOUT_EN
                    w_tmo_cnt_nx = r_tx_rdone ? 10'd0 : (r_tmo_cnt + 10'd1);
`endif
                    if (|r_req_r_en) begin
                        // Read outstanding: only the owner's completion counts.
                        if (|(req_rdone & r_grant)) begin
                            w_tx_data_nx  = w_g ? req_data1 : req_data0;
                            w_tx_rdone_nx = 1'b1;
                            w_req_r_en_nx = 2'b00;
                        end
                    end else if (tx_r_en) begin
                        w_req_r_en_nx = r_grant;
                        w_req_ptr_nx  = tx_ptr;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state    <= ST_IDLE;
            r_pending  <= 2'b00;
            r_last     <= 1'b1;
            r_grant    <= 2'b00;
            r_tx_end   <= 32'd0;
            r_tx_send  <= 1'b0;
            r_tx_data  <= 32'd0;
            r_tx_rdone <= 1'b0;
            r_req_done <= 2'b00;
            r_req_r_en <= 2'b00;
            r_req_ptr  <= 32'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            // A new send pulse re-arms pending even on the clearing edge.
            r_pending  <= (r_pending & ~w_pend_clr) | req_send;
            r_last     <= w_last_nx;
            r_grant    <= w_grant_nx;
            r_tx_end   <= w_tx_end_nx;
            r_tx_send  <= w_tx_send_nx;
            r_tx_data  <= w_tx_data_nx;
            r_tx_rdone <= w_tx_rdone_nx;
            r_req_done <= w_req_done_nx;
            r_req_r_en <= w_req_r_en_nx;
            r_req_ptr  <= w_req_ptr_nx;
            r_busy     <= (w_state_nx == ST_BUSY);
        end
    end

    // Per-requester region_end capture on every send pulse.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_end0 <= 32'd0;
            r_end1 <= 32'd0;
        end else begin
            if (req_send[0]) r_end0 <= req_end0;
            if (req_send[1]) r_end1 <= req_end1;
        end
    end

`ifdef CMD_ARB_TIMEOUT_EN
    // Watchdog counter and abort pulse.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_tmo_cnt   <= 10'd0;
            r_abort_err <= 1'b0;
        end else begin
            r_tmo_cnt   <= w_tmo_cnt_nx;
            r_abort_err <= w_abort_nx;
        end
    end

    assign abort_err = r_abort_err;
`else
    assign abort_err = 1'b0;
`endif

    assign req_r_en = r_req_r_en;
    assign req_ptr  = r_req_ptr;
    assign req_done = r_req_done;
    assign tx_send  = r_tx_send;
    assign tx_end   = r_tx_end;
    assign tx_data  = r_tx_data;
    assign tx_rdone = r_tx_rdone;
    assign grant    = r_grant;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_arbiter
// Description : Scoreboard bench for cmd_arbiter. Stimulus pushes expected
//               grants, reads and completions; a negedge monitor pops and
//               compares whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_arbiter;

    logic        clk;
    logic        rst_L;
    logic [1:0]  req_send;
    logic [31:0] req_end0, req_end1, req_data0, req_data1;
    logic [1:0]  req_rdone;
    logic [1:0]  req_r_en;
    logic [31:0] req_ptr;
    logic [1:0]  req_done;
    logic        tx_send;
    logic [31:0] tx_end;
    logic        tx_r_en;
    logic [31:0] tx_ptr;
    logic [31:0] tx_data;
    logic        tx_rdone;
    logic        tx_done;
    logic [1:0]  grant;
    logic        busy;
    logic        abort_err;

    cmd_arbiter dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .req_send  (req_send),
        .req_end0  (req_end0),
        .req_end1  (req_end1),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_rdone (req_rdone),
        .req_r_en  (req_r_en),
        .req_ptr   (req_ptr),
        .req_done  (req_done),
        .tx_send   (tx_send),
        .tx_end    (tx_end),
        .tx_r_en   (tx_r_en),
        .tx_ptr    (tx_ptr),
        .tx_data   (tx_data),
        .tx_rdone  (tx_rdone),
        .tx_done   (tx_done),
        .grant     (grant),
        .busy      (busy),
        .abort_err (abort_err)
    );

    typedef struct {
        logic [1:0]  g;
        logic [31:0] e;
        int          cyc;
    } send_t;

    typedef struct {
        logic [1:0]  d;
        logic        ab;
    } done_t;

    send_t        q_send[$];
    done_t        q_done[$];
    logic [31:0]  q_rd[$];
    logic [33:0]  q_ptr[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_unexp(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: pop and compare on every visible DUT event.
    logic prev_send, prev_rdone;
    logic [1:0] prev_ren;
    always @(negedge clk) begin
        if (rst_L) begin
            if (tx_send) begin
                chk("tx_send_single", {63'd0, prev_send}, 64'd0);
                if (q_send.size() == 0) begin
                    fail_unexp("tx_send", {30'd0, grant, tx_end});
                end else begin
                    send_t s;
                    s = q_send.pop_front();
                    chk("grant", {62'd0, grant}, {62'd0, s.g});
                    chk("tx_end", {32'd0, tx_end}, {32'd0, s.e});
                    chk("send_cycle", 64'(cyc), 64'(s.cyc));
                    chk("busy_on_send", {63'd0, busy}, 64'd1);
                end
            end
            if (tx_rdone) begin
                chk("tx_rdone_single", {63'd0, prev_rdone}, 64'd0);
                if (q_rd.size() == 0) fail_unexp("tx_rdone", {32'd0, tx_data});
                else chk("tx_data", {32'd0, tx_data}, {32'd0, q_rd.pop_front()});
            end
            if (req_done != 2'b00) begin
                if (q_done.size() == 0) begin
                    fail_unexp("req_done", {62'd0, req_done});
                end else begin
                    done_t d;
                    d = q_done.pop_front();
                    chk("req_done", {62'd0, req_done}, {62'd0, d.d});
                    chk("abort_err", {63'd0, abort_err}, {63'd0, d.ab});
                    chk("busy_after_done", {63'd0, busy}, 64'd0);
                    chk("grant_after_done", {62'd0, grant}, 64'd0);
                end
            end
            if (req_r_en != 2'b00 && prev_ren == 2'b00) begin
                if (q_ptr.size() == 0) fail_unexp("req_r_en", {30'd0, req_r_en, req_ptr});
                else chk("req_r_en_ptr", {30'd0, req_r_en, req_ptr}, {30'd0, q_ptr.pop_front()});
            end
            prev_send  <= tx_send;
            prev_rdone <= tx_rdone;
            prev_ren   <= req_r_en;
        end else begin
            prev_send  <= 1'b0;
            prev_rdone <= 1'b0;
            prev_ren   <= 2'b00;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_send(input logic [1:0] s, input logic [31:0] e0, input logic [31:0] e1);
        req_send = s;
        req_end0 = e0;
        req_end1 = e1;
        tick();
        req_send = 2'b00;
    endtask

    task automatic exp_send(input logic [1:0] g, input logic [31:0] e, input int c);
        send_t s;
        s.g = g; s.e = e; s.cyc = c;
        q_send.push_back(s);
    endtask

    task automatic exp_done(input logic [1:0] d, input logic ab);
        done_t x;
        x.d = d; x.ab = ab;
        q_done.push_back(x);
    endtask

    // Drive tx_done for one cycle, expecting completion of owner g.
    task automatic finish_xfer(input logic [1:0] g);
        tx_done = 1'b1;
        exp_done(g, 1'b0);
        tick();
        tx_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {62'd0, req_r_en}, 64'd0);
        chk({name, "_ptr"}, {32'd0, req_ptr}, 64'd0);
        chk({name, "_misc"}, {56'd0, req_done, tx_send, tx_rdone, grant, busy, abort_err}, 64'd0);
        chk({name, "_tx_end"}, {32'd0, tx_end}, 64'd0);
        chk({name, "_tx_data"}, {32'd0, tx_data}, 64'd0);
    endtask

    initial begin
        rst_L = 1'b1; req_send = '0; req_end0 = '0; req_end1 = '0;
        req_data0 = '0; req_data1 = '0; req_rdone = '0;
        tx_r_en = 1'b0; tx_ptr = '0; tx_done = 1'b0;
        #1 rst_L = 1'b0;
        #1 chk_all_zero("reset");
        while (cyc < 2) tick();
        rst_L = 1'b1;

        // Single request, read forwarding, idle tx_done ignored.
        while (cyc != 5) tick();
        exp_send(2'b01, 32'd3, 7);
        pulse_send(2'b01, 32'd3, 32'd0);
        tick();
        tx_r_en = 1'b1; tx_ptr = 32'd2;
        q_ptr.push_back({2'b01, 32'd2});
        tick();
        tx_r_en = 1'b0;
        req_rdone = 2'b10; req_data1 = 32'hDEADBEEF;
        tick();
        req_rdone = 2'b01; req_data0 = 32'h4F6B6179;
        q_rd.push_back(32'h4F6B6179);
        tick();
        req_rdone = 2'b00;
        tick();
        finish_xfer(2'b01);
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick(); tick();

        // Reset in the middle of BUSY with a read outstanding.
        exp_send(2'b10, 32'd7, cyc + 2);
        pulse_send(2'b10, 32'd0, 32'd7);
        tick();
        tx_r_en = 1'b1; tx_ptr = 32'd5;
        q_ptr.push_back({2'b10, 32'd5});
        tick();
        tx_r_en = 1'b0;
        tick();
        #2 rst_L = 1'b0;
        #1 chk_all_zero("reset_mid_busy");
        tick(); tick();
        rst_L = 1'b1;
        tick();
        exp_send(2'b01, 32'd3, cyc + 2);
        pulse_send(2'b01, 32'd3, 32'd0);
        tick();
        finish_xfer(2'b01);
        tick(); tick();

        // Simultaneous requests from a fresh reset.
        rst_L = 1'b0;
        tick();
        rst_L = 1'b1;
        tick();
        exp_send(2'b01, 32'd5, cyc + 2);
        pulse_send(2'b11, 32'd5, 32'd6);
        tick();
        exp_send(2'b10, 32'd6, cyc + 2);
        finish_xfer(2'b01);
        tick();
        finish_xfer(2'b10);
        tick();
        exp_send(2'b01, 32'd8, cyc + 2);
        pulse_send(2'b11, 32'd8, 32'd9);
        tick();
        exp_send(2'b10, 32'd9, cyc + 2);
        finish_xfer(2'b01);
        tick();
        finish_xfer(2'b10);
        tick(); tick();

        // Re-arm race: requester 1 resends on its own tx_done edge.
        exp_send(2'b10, 32'h11, cyc + 2);
        pulse_send(2'b10, 32'd0, 32'h11);
        tick();
        pulse_send(2'b01, 32'h20, 32'h11);
        tick();
        req_send = 2'b10; req_end1 = 32'h12;
        exp_send(2'b01, 32'h20, cyc + 2);
        finish_xfer(2'b10);
        req_send = 2'b00;
        tick();
        exp_send(2'b10, 32'h12, cyc + 2);
        finish_xfer(2'b01);
        tick();
        finish_xfer(2'b10);
        tick(); tick(); tick();

`ifdef CMD_ARB_TIMEOUT_EN
        // Stalled transfer is aborted by the watchdog.
        begin
            int start;
            int n;
            bit seen;
            seen = 1'b0;
            n = 0;
            exp_send(2'b01, 32'h33, cyc + 2);
            exp_done(2'b01, 1'b1);
            pulse_send(2'b01, 32'h33, 32'd0);
            tick();
            start = cyc;
            for (int i = 0; i < 1200; i++) begin
                if (abort_err) begin
                    seen = 1'b1;
                    n = cyc - start;
                    break;
                end
                tick();
            end
            chk("timeout_seen", {63'd0, seen}, 64'd1);
            chk("timeout_window", {63'd0, (n >= 1020 && n <= 1028)}, 64'd1);
            tick(); tick();
        end
`endif

        tick(); tick(); tick();
        chk("q_send_empty", 64'(q_send.size()), 64'd0);
        chk("q_done_empty", 64'(q_done.size()), 64'd0);
        chk("q_rd_empty", 64'(q_rd.size()), 64'd0);
        chk("q_ptr_empty", 64'(q_ptr.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk input 1 rising-edge clock; rst_L input 1 async active-low reset.
REQ-002 SHALL have req_send input 2: per-requester one-cycle "command buffer ready" pulse.
REQ-003 SHALL have req_end0, req_end1 input 32 each: requester region_end, valid with req_send.
REQ-004 SHALL have req_data0, req_data1 input 32 each: requester read data.
REQ-005 SHALL have req_rdone input 2: requester read-complete pulse.
REQ-006 SHALL have req_r_en output 2: read enable to the granted requester.
REQ-007 SHALL have req_ptr output 32: word pointer to the requesters.
REQ-008 SHALL have req_done output 2: per-requester transfer-complete pulse.
REQ-009 SHALL have tx_send output 1: start pulse to the SPI transmitter.
REQ-010 SHALL have tx_end output 32: region_end of the granted command.
REQ-011 SHALL have tx_r_en input 1 and tx_ptr input 32: transmitter read request and word pointer.
REQ-012 SHALL have tx_data output 32: read data to the transmitter.
REQ-013 SHALL have tx_rdone output 1: read-complete pulse to the transmitter.
REQ-014 SHALL have tx_done input 1: transmitter transfer-complete pulse.
REQ-015 SHALL have grant output 2: one-hot owner, 0 when idle; busy output 1: high outside IDLE; abort_err output 1: timeout pulse.

Function
REQ-016 SHALL latch req_send[i] into pending[i] and capture req_endi into an internal end register on the same edge.
REQ-017 SHALL implement states IDLE -> BUSY -> IDLE.
REQ-018 SHALL, in IDLE with pending nonzero, pick a winner by round-robin against last-granted.
REQ-019 SHALL, on the IDLE exit edge, register grant, register tx_end from the winner's end register, pulse tx_send for one cycle and enter BUSY.
REQ-020 SHALL produce latency req_send in cycle k (idle, nothing pending) -> tx_send and grant in cycle k+2.
REQ-021 SHALL, in BUSY, when tx_r_en=1 and no read is outstanding, assert req_r_en[g] and drive req_ptr=tx_ptr until req_rdone[g].
REQ-022 SHALL, on req_rdone[g], register tx_data from req_datag, pulse tx_rdone one cycle and drop req_r_en[g].
REQ-023 SHALL allow at most one read outstanding and SHALL ignore req_rdone from the non-granted requester.
REQ-024 SHALL, on tx_done in BUSY, pulse req_done[g], clear pending[g], set last-granted=g, clear grant and return to IDLE on the same edge.
REQ-025 SHALL set pending again if req_send[g] arrives on the tx_done edge or during BUSY (set wins over clear) and SHALL overwrite that requester's end register.
REQ-026 SHALL ignore tx_done in IDLE; tx_send and tx_rdone SHALL never be high for more than one consecutive cycle.
REQ-027 SHALL register every output except req_r_en and req_ptr, which SHALL be registered from internal state.

Reset
REQ-028 SHALL, on rst_L low, immediately and asynchronously force state=IDLE, pending=0, last-granted=1 (requester 0 wins first), all outputs 0, and end and data registers 0.
REQ-029 SHALL abandon any in-flight transfer on reset mid-BUSY without pulsing req_done.

Configuration
REQ-030 SHALL, with CMD_ARB_TIMEOUT_EN defined, include a 10-bit counter cleared on BUSY entry and on each tx_rdone, incrementing otherwise in BUSY.
REQ-031 SHALL, with CMD_ARB_TIMEOUT_EN defined, on the counter reaching 1023 pulse abort_err and req_done[g] together, clear pending[g] and grant and drop req_r_en, and return to IDLE.
REQ-032 SHALL, without CMD_ARB_TIMEOUT_EN, omit the counter, tie abort_err to 0 and wait in BUSY indefinitely for tx_done.

Verification
REQ-033 SHALL cover single request: req_send[0] with req_end0=3 in cycle 5 -> tx_send, grant=01 and tx_end=3 in cycle 7.
REQ-034 SHALL cover a read: tx_r_en with tx_ptr=2, req_rdone[0] with req_data0=0x4F6B6179 -> req_ptr=2, then tx_data=0x4F6B6179 with one tx_rdone pulse.
REQ-035 SHALL cover a simultaneous request: req_send=11 -> grant 01 first, then 10 after tx_done, then 01 for the next simultaneous pair.
REQ-036 SHALL cover a rearm race: req_send[1] on the same cycle as tx_done for requester 1 with requester 0 pending -> requester 0 granted next, then requester 1 again.
REQ-037 SHALL cover reset mid-BUSY: rst_L low -> all outputs 0 at once, no req_done; first request after reset is handled per REQ-033.
REQ-038 SHALL cover timeout with CMD_ARB_TIMEOUT_EN: no tx_done or tx_rdone for 1023 BUSY cycles -> abort_err and req_done[g] pulse, busy=0 the next cycle.
